// File: rtl/calc_pkg.sv
// Shared calculator definitions: selector FSM states and default datapath sizing.
package calc_pkg;

  typedef enum logic {
    CALC_SEL_IDLE  = 1'b0,
    CALC_SEL_ARMED = 1'b1
  } calc_sel_state_e;

  localparam int unsigned CALC_WIDTH  = 16;
  localparam int unsigned CALC_NUM_CH = 4;

endpackage : calc_pkg

// File: rtl/calc_result_sel_if.sv
// Select, per-channel operand/result and output handshakes of the result selector.
interface calc_result_sel_if
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = CALC_WIDTH,
  parameter int unsigned NUM_CH = CALC_NUM_CH
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [SEL_W-1:0]        sel;
  logic                    sel_valid;
  logic                    sel_ready;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output sel, sel_valid, in_data, in_valid, out_ready,
    input  sel_ready, in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  sel, sel_valid, in_data, in_valid, out_ready,
    output sel_ready, in_ready, out_data, out_ch, out_valid
  );

endinterface : calc_result_sel_if

// File: rtl/calc_skid_fifo2.sv
// Two-entry registered FIFO; head is always a flop, push data is never bypassed.
module calc_skid_fifo2 #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign pop_data = head_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        if (empty) head_d = push_data;
        else       tail_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Head keeps the last popped value once the FIFO drains
        if (full) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : calc_skid_fifo2

// File: rtl/calc_result_sel.sv
// Latches an op select, takes one result from the chosen channel and queues it
// with its channel index into a 2-entry output FIFO.
module calc_result_sel
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = CALC_WIDTH,
  parameter int unsigned NUM_CH = CALC_NUM_CH,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  calc_result_sel_if.slave  bus,
  output logic              err_sel,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);
  localparam int unsigned DW    = WIDTH + SEL_W;

  calc_sel_state_e  state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_sel_q, err_sel_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic              sel_in_range_c;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [DW-1:0]     fifo_head;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] in_ready;
  logic [WIDTH-1:0]  gated [NUM_CH];
  logic [WIDTH-1:0]  sel_data;

  assign sel_in_range_c = (32'(bus.sel) < NUM_CH);

  // Per-channel AND gating of data and ready by the latched select
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign hit[c]      = (sel_q == SEL_W'(c));
    assign in_ready[c] = (state_q == CALC_SEL_ARMED) && hit[c] && !fifo_full;
    assign gated[c]    = bus.in_data[c*WIDTH +: WIDTH] & {WIDTH{hit[c]}};
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) sel_data = sel_data | gated[c];
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    err_sel_d = err_sel_q;
    push      = 1'b0;
    unique case (state_q)
      CALC_SEL_IDLE: begin
        if (bus.sel_valid) begin
          if (sel_in_range_c) begin
            state_d = CALC_SEL_ARMED;
            sel_d   = bus.sel;
          end else begin
            err_sel_d = 1'b1;
          end
        end
      end
      CALC_SEL_ARMED: begin
        if (|(bus.in_valid & in_ready)) begin
          push    = 1'b1;
          state_d = CALC_SEL_IDLE;
        end
      end
      default: state_d = CALC_SEL_IDLE;
    endcase
  end

  assign pop        = !fifo_empty && bus.out_ready;
  assign xfer_cnt_d = xfer_cnt_q + CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CALC_SEL_IDLE;
      sel_q      <= '0;
      err_sel_q  <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      err_sel_q  <= err_sel_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  calc_skid_fifo2 #(.DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({sel_q, sel_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.sel_ready = (state_q == CALC_SEL_IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.out_data  = fifo_head[WIDTH-1:0];
  assign bus.out_ch    = fifo_head[DW-1:WIDTH];
  assign bus.out_valid = !fifo_empty;
  assign err_sel       = err_sel_q;
  assign xfer_cnt      = xfer_cnt_q;

endmodule : calc_result_sel
